desk_clock_wrapper: RTL and testbench



---
 rtl/desk_clock_wrapper.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_desk_clock_wrapper.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/desk_clock_wrapper.sv
// Desk clock top: refclk synchronizer, strobe generator, BCD timekeeping with button setting,
// and a MAX7219 serial driver that re-sends the display frame whenever the time changes.
module desk_clock_wrapper #(
  parameter int unsigned REFCLK_HZ    = 32768,
  parameter int unsigned SLOW_SET_DIV = 16384,
  parameter int unsigned FAST_SET_DIV = 4096,
  parameter int unsigned DEBOUNCE_DIV = 128
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_refclk,
  input  logic i_en,
  input  logic i_fast_set,
  input  logic i_set_hours,
  input  logic i_set_minutes,
  output logic o_serial_dout,
  output logic o_serial_load,
  output logic o_serial_clk
);

  localparam int unsigned CntW = $clog2(REFCLK_HZ);
  localparam logic [CntW-1:0] SlowMask = CntW'(SLOW_SET_DIV - 1);
  localparam logic [CntW-1:0] FastMask = CntW'(FAST_SET_DIV - 1);
  localparam logic [CntW-1:0] DebMask  = CntW'(DEBOUNCE_DIV - 1);
  localparam logic [3:0] FirstDigit = 4'd5;
  localparam logic [3:0] FrameDone  = 4'd13;

  typedef enum logic [1:0] {StIdle, StShift, StLoad, StGap} ser_state_e;

  function automatic logic [7:0] inc_bcd60(input logic [7:0] v);
    if (v[3:0] == 4'd9) return (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc_bcd24(input logic [7:0] v);
    if (v == 8'h23) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    logic [7:0] s;
    unique case (d)
      4'd0:    s = 8'h7E;
      4'd1:    s = 8'h30;
      4'd2:    s = 8'h6D;
      4'd3:    s = 8'h79;
      4'd4:    s = 8'h33;
      4'd5:    s = 8'h5B;
      4'd6:    s = 8'h5F;
      4'd7:    s = 8'h70;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h7B;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  // Words 0..4 are the power-up config, 5..12 are digit registers 1..8.
  function automatic logic [15:0] word_data(input logic [3:0] idx, input logic [7:0] hh,
                                            input logic [7:0] mm, input logic [7:0] ss);
    logic [15:0] w;
    unique case (idx)
      4'd0:    w = 16'h0C01;
      4'd1:    w = 16'h0900;
      4'd2:    w = 16'h0B07;
      4'd3:    w = 16'h0A08;
      4'd4:    w = 16'h0F00;
      4'd5:    w = {8'h01, seg_of(hh[7:4])};
      4'd6:    w = {8'h02, seg_of(hh[3:0])};
      4'd7:    w = {8'h03, seg_of(mm[7:4])};
      4'd8:    w = {8'h04, seg_of(mm[3:0])};
      4'd9:    w = {8'h05, seg_of(ss[7:4])};
      4'd10:   w = {8'h06, seg_of(ss[3:0])};
      4'd11:   w = 16'h0700;
      4'd12:   w = 16'h0800;
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  // refclk synchronizer and rising-edge strobe
  logic [2:0] ref_sync_q, ref_sync_d;
  logic       ref_stb_q, ref_stb_d;

  // strobe generator
  logic [CntW-1:0] cnt_q, cnt_d;
  logic one_hz_q, one_hz_d, slow_q, slow_d, fast_q, fast_d, deb_stb_q, deb_stb_d;

  // buttons: bit 1 = hours, bit 0 = minutes
  logic [1:0] btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic [1:0] btn_samp_q, btn_samp_d, btn_deb_q, btn_deb_d;

  logic [7:0] hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic       set_stb, hold_h, hold_m, time_chg;

  always_comb begin
    ref_sync_d = {ref_sync_q[1:0], i_refclk};
    ref_stb_d  = ref_sync_q[1] & ~ref_sync_q[2];

    cnt_d     = ref_stb_q ? cnt_q + CntW'(1) : cnt_q;
    one_hz_d  = ref_stb_q && (cnt_d == '0);
    slow_d    = ref_stb_q && ((cnt_d & SlowMask) == '0);
    fast_d    = ref_stb_q && ((cnt_d & FastMask) == '0);
    deb_stb_d = ref_stb_q && ((cnt_d & DebMask) == '0);

    btn_s1_d   = {i_set_hours, i_set_minutes};
    btn_s2_d   = btn_s1_q;
    btn_samp_d = btn_samp_q;
    btn_deb_d  = btn_deb_q;
    if (deb_stb_q) begin
      btn_samp_d = btn_s2_q;
      // A bit follows the input only once two consecutive strobe samples agree.
      btn_deb_d  = (btn_s2_q & ~(btn_s2_q ^ btn_samp_q)) | (btn_deb_q & (btn_s2_q ^ btn_samp_q));
    end
  end

  assign set_stb = i_fast_set ? fast_q : slow_q;
  assign hold_h  = btn_deb_q[1];
  assign hold_m  = btn_deb_q[0];

  always_comb begin
    hh_d = hh_q;
    mm_d = mm_q;
    ss_d = ss_q;
    if (i_en) begin
      if (hold_h && hold_m) begin
        if (set_stb) ss_d = 8'h00;
        else if (one_hz_q) ss_d = inc_bcd60(ss_q);
      end else begin
        if (one_hz_q) ss_d = inc_bcd60(ss_q);
        if (hold_h && set_stb) hh_d = inc_bcd24(hh_q);
        if (hold_m && set_stb) mm_d = inc_bcd60(mm_q);
        // Carries only ripple while no button is held.
        if (!hold_h && !hold_m && one_hz_q && ss_q == 8'h59) begin
          mm_d = inc_bcd60(mm_q);
          if (mm_q == 8'h59) hh_d = inc_bcd24(hh_q);
        end
      end
    end
  end

  assign time_chg = (hh_d != hh_q) || (mm_d != mm_q) || (ss_d != ss_q);

  // serializer
  ser_state_e  state_q, state_d;
  logic [3:0]  word_q, word_d, bit_q, bit_d, next_idx;
  logic [15:0] shreg_q, shreg_d, next_word;
  logic        phase_q, phase_d, wait_q, wait_d, pending_q, pending_d;
  logic        dout_q, dout_d, load_q, load_d, sclk_q, sclk_d;
  logic        boundary, start_word, clr_pending;

  always_comb begin
    start_word  = 1'b0;
    clr_pending = 1'b0;
    next_idx    = word_q;
    if (word_q < FirstDigit) begin
      start_word = 1'b1;
    end else if (pending_q) begin
      start_word  = 1'b1;
      clr_pending = 1'b1;
      next_idx    = FirstDigit;
    end else if (word_q != FrameDone) begin
      start_word = 1'b1;
    end
    next_word = word_data(next_idx, hh_q, mm_q, ss_q);
    boundary  = (state_q == StIdle) || (state_q == StGap && wait_q);

    state_d   = state_q;
    word_d    = word_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    phase_d   = phase_q;
    wait_d    = wait_q;
    dout_d    = dout_q;
    load_d    = load_q;
    sclk_d    = sclk_q;
    pending_d = (pending_q & ~(boundary & clr_pending)) | time_chg;

    unique case (state_q)
      StIdle, StGap: begin
        if (state_q == StGap && !wait_q) begin
          wait_d = 1'b1;
        end else if (start_word) begin
          state_d = StShift;
          shreg_d = next_word;
          dout_d  = next_word[15];
          sclk_d  = 1'b0;
          phase_d = 1'b0;
          bit_d   = 4'd0;
          wait_d  = 1'b0;
          word_d  = next_idx + 4'd1;
        end else begin
          state_d = StIdle;
          wait_d  = 1'b0;
        end
      end
      StShift: begin
        if (!phase_q) begin
          sclk_d  = 1'b1;
          phase_d = 1'b1;
        end else begin
          sclk_d  = 1'b0;
          phase_d = 1'b0;
          if (bit_q == 4'd15) begin
            state_d = StLoad;
            load_d  = 1'b1;
            dout_d  = 1'b0;
            wait_d  = 1'b0;
          end else begin
            shreg_d = {shreg_q[14:0], 1'b0};
            dout_d  = shreg_q[14];
            bit_d   = bit_q + 4'd1;
          end
        end
      end
      StLoad: begin
        if (!wait_q) begin
          wait_d = 1'b1;
        end else begin
          load_d  = 1'b0;
          wait_d  = 1'b0;
          state_d = StGap;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ref_sync_q <= '0;
      ref_stb_q  <= 1'b0;
      cnt_q      <= '0;
      one_hz_q   <= 1'b0;
      slow_q     <= 1'b0;
      fast_q     <= 1'b0;
      deb_stb_q  <= 1'b0;
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      btn_samp_q <= '0;
      btn_deb_q  <= '0;
      hh_q       <= 8'h00;
      mm_q       <= 8'h00;
      ss_q       <= 8'h00;
      state_q    <= StIdle;
      word_q     <= 4'd0;
      bit_q      <= 4'd0;
      shreg_q    <= '0;
      phase_q    <= 1'b0;
      wait_q     <= 1'b0;
      pending_q  <= 1'b1;  // forces the first frame after the config words
      dout_q     <= 1'b0;
      load_q     <= 1'b0;
      sclk_q     <= 1'b0;
    end else begin
      ref_sync_q <= ref_sync_d;
      ref_stb_q  <= ref_stb_d;
      cnt_q      <= cnt_d;
      one_hz_q   <= one_hz_d;
      slow_q     <= slow_d;
      fast_q     <= fast_d;
      deb_stb_q  <= deb_stb_d;
      btn_s1_q   <= btn_s1_d;
      btn_s2_q   <= btn_s2_d;
      btn_samp_q <= btn_samp_d;
      btn_deb_q  <= btn_deb_d;
      hh_q       <= hh_d;
      mm_q       <= mm_d;
      ss_q       <= ss_d;
      state_q    <= state_d;
      word_q     <= word_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      phase_q    <= phase_d;
      wait_q     <= wait_d;
      pending_q  <= pending_d;
      dout_q     <= dout_d;
      load_q     <= load_d;
      sclk_q     <= sclk_d;
    end
  end

  assign o_serial_dout = dout_q;
  assign o_serial_load = load_q;
  assign o_serial_clk  = sclk_q;

endmodule

// File: tb/tb_desk_clock_wrapper.sv
// Bench for desk_clock_wrapper: decodes the MAX7219 bus into a register image and checks it
// against hand-computed times after each directed set/run phase.
module tb_desk_clock_wrapper;
  localparam int unsigned RefHz = 32;
  localparam int unsigned SlowDiv = 16;
  localparam int unsigned FastDiv = 4;
  localparam int unsigned DebDiv = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, refclk, en, fast, bh, bm;
  logic dout, load, sclk;

  desk_clock_wrapper #(
    .REFCLK_HZ   (RefHz),
    .SLOW_SET_DIV(SlowDiv),
    .FAST_SET_DIV(FastDiv),
    .DEBOUNCE_DIV(DebDiv)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_refclk     (refclk),
    .i_en         (en),
    .i_fast_set   (fast),
    .i_set_hours  (bh),
    .i_set_minutes(bm),
    .o_serial_dout(dout),
    .o_serial_load(load),
    .o_serial_clk (sclk)
  );

  int checks = 0;
  int errors = 0;
  int ref_cnt = 0;

  // bus decoder
  logic        sclk_p = 1'b0, load_p = 1'b0, dout_p = 1'b0;
  logic [15:0] sh = '0;
  logic [15:0] wlog[0:1023];
  logic [7:0]  disp[0:15];
  int nbits = 0, load_w = 0, loads = 0, idle = 0, proto_err = 0;

  always @(negedge clk) begin
    if (rst) begin
      nbits  = 0;
      load_w = 0;
      for (int i = 0; i < 16; i++) disp[i] = 8'hFF;
    end else begin
      if (sclk && !sclk_p) begin
        sh = {sh[14:0], dout};
        nbits++;
      end
      if (sclk && sclk_p && dout != dout_p) proto_err++;
      if (load && !load_p) begin
        if (nbits != 16) proto_err++;
        if (loads < 1024) wlog[loads] = sh;
        loads++;
        if (sh[15:12] == 4'h0) disp[sh[11:8]] = sh[7:0];
        nbits = 0;
      end
      if (load) load_w++;
      else if (load_p) begin
        if (load_w != 2) proto_err++;
        load_w = 0;
      end
    end
    idle   = (sclk || load) ? 0 : idle + 1;
    sclk_p = sclk;
    load_p = load;
    dout_p = dout;
  end

  function automatic logic [7:0] seg(input int d);
    case (d)
      0: return 8'h7E;
      1: return 8'h30;
      2: return 8'h6D;
      3: return 8'h79;
      4: return 8'h33;
      5: return 8'h5B;
      6: return 8'h5F;
      7: return 8'h70;
      8: return 8'h7F;
      9: return 8'h7B;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      refclk = 1'b1;
      repeat (3) @(negedge clk);
      refclk = 1'b0;
      repeat (3) @(negedge clk);
      ref_cnt++;
    end
  endtask

  task automatic wait_quiet(input string name);
    bit ok;
    ok = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (idle >= 60) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, ".quiet"}, 32'(ok), 32'd1);
    chk({name, ".protocol"}, 32'(proto_err), 32'd0);
  endtask

  task automatic check_disp(input string name, input int hh, input int mm, input int ss);
    chk({name, ".h10"}, 32'(disp[1]), 32'(seg(hh / 10)));
    chk({name, ".h1"},  32'(disp[2]), 32'(seg(hh % 10)));
    chk({name, ".m10"}, 32'(disp[3]), 32'(seg(mm / 10)));
    chk({name, ".m1"},  32'(disp[4]), 32'(seg(mm % 10)));
    chk({name, ".s10"}, 32'(disp[5]), 32'(seg(ss / 10)));
    chk({name, ".s1"},  32'(disp[6]), 32'(seg(ss % 10)));
    chk({name, ".d6"},  32'(disp[7]), 32'h00);
    chk({name, ".d7"},  32'(disp[8]), 32'h00);
  endtask

  typedef struct {
    logic bh, bm, fast, en;
    int   n;
    int   hh, mm, ss;
  } vec_t;

  vec_t vecs[12];
  logic [15:0] boot[13];
  int base;

  initial begin
    // Each phase starts with the refclk counter at zero; n refclk edges then follow.
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b1,   40, 10,  0,  1};  // hours fast
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1,  236, 10, 59,  8};  // minutes fast, no carry
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1,    8, 10, 59,  0};  // both: seconds cleared
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1952, 11,  0,  1};  // 61 s run
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1,  192, 23,  0,  7};  // hours slow
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1,  944, 23, 59, 36};  // minutes slow
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1,   16, 23, 59,  0};  // both slow
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1952,  0,  0,  1};  // day wrap
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0,  160,  0,  0,  1};  // disabled: frozen
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1,   96,  0,  0,  4};  // hours 23->00 wrap
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1,  240,  0,  0, 11};  // minutes 59->00, hours kept
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1568,  0,  1,  0};  // 49 s run with carry
    boot = '{16'h0C01, 16'h0900, 16'h0B07, 16'h0A08, 16'h0F00, 16'h017E, 16'h027E,
             16'h037E, 16'h047E, 16'h057E, 16'h067E, 16'h0700, 16'h0800};

    rst = 1'b1; refclk = 1'b0; en = 1'b0; fast = 1'b0; bh = 1'b0; bm = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.dout", 32'(dout), 32'd0);
    chk("reset.load", 32'(load), 32'd0);
    chk("reset.sclk", 32'(sclk), 32'd0);
    rst = 1'b0;

    // Abort in the middle of the second config word.
    repeat (50) @(negedge clk);
    chk("midword.busy", 32'(loads), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midword.dout", 32'(dout), 32'd0);
    chk("midword.load", 32'(load), 32'd0);
    chk("midword.sclk", 32'(sclk), 32'd0);
    rst = 1'b0;
    base = loads;
    wait_quiet("boot");
    chk("boot.count", 32'(loads - base), 32'd13);
    for (int i = 0; i < 13; i++)
      chk($sformatf("boot.word%0d", i), 32'(wlog[base + i]), 32'(boot[i]));
    check_disp("boot", 0, 0, 0);

    for (int v = 0; v < 12; v++) begin
      en   = 1'b0;
      bh   = vecs[v].bh;
      bm   = vecs[v].bm;
      fast = vecs[v].fast;
      repeat (4) @(negedge clk);
      pulse(4);
      while (ref_cnt % RefHz != 0) pulse(1);
      en = vecs[v].en;
      pulse(vecs[v].n);
      en = 1'b0;
      wait_quiet($sformatf("vec%0d", v));
      check_disp($sformatf("vec%0d", v), vecs[v].hh, vecs[v].mm, vecs[v].ss);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
